// File: rtl/com_cg_ctl.sv
// Idle-detect clock-gate enable controller: drops the gater enable after a run
// of idle cycles and restores it on new work or a wake request.
//
// state    | meaning
// ST_RUN   | clock running, counting consecutive idle cycles
// ST_GATED | clock stopped, waiting for busy or wake_req
// ST_WAKE  | clock re-enabled, settling for WAKE_LAT cycles
module com_cg_ctl #(
  parameter int IDLE_CNT_W = 8,
  parameter int WAKE_LAT   = 2,
  parameter int EVT_W      = 16
) (
  input  logic                  inclk,
  input  logic                  reset,
  input  logic                  busy,
  input  logic                  wake_req,
  input  logic [IDLE_CNT_W-1:0] idle_thresh,
  input  logic                  test_en,
  output logic                  cg_en,
  output logic                  wake_ack,
  output logic                  gated,
  output logic [EVT_W-1:0]      gate_evts
);

  localparam int WCNT_W = 4;
  localparam logic [WCNT_W-1:0] WAKE_LOAD = WCNT_W'(WAKE_LAT - 1);
  localparam logic [IDLE_CNT_W-1:0] IDLE_ONE = IDLE_CNT_W'(1);

  typedef enum logic [1:0] {ST_RUN, ST_GATED, ST_WAKE} state_t;

  state_t                  state, state_nxt;
  logic [IDLE_CNT_W-1:0]   idle_cnt, idle_cnt_nxt;
  logic [WCNT_W-1:0]       wake_cnt, wake_cnt_nxt;
  logic [IDLE_CNT_W-1:0]   thresh_m1;
  logic                    idle;
  logic                    gate_fire;
  logic                    cg_en_q;
  logic                    gated_q;

  assign idle      = !busy && !wake_req;
  assign thresh_m1 = idle_thresh - IDLE_ONE;

  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      idle_cnt  <= '0;
      wake_cnt  <= '0;
      cg_en_q   <= 1'b1;
      gated_q   <= 1'b0;
      wake_ack  <= 1'b0;
      gate_evts <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
      wake_cnt <= wake_cnt_nxt;
      // enable and status are registered so the gater sees a glitch-free level
      cg_en_q  <= (state_nxt != ST_GATED);
      gated_q  <= (state_nxt == ST_GATED);
      wake_ack <= (state == ST_RUN) && wake_req && !wake_ack;
      if (gate_fire && (gate_evts != '1))
        gate_evts <= gate_evts + EVT_W'(1);
    end
  end

  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    wake_cnt_nxt = wake_cnt;
    gate_fire    = 1'b0;
    case (state)
      ST_RUN: begin
        if (idle && (idle_thresh != '0)) begin
          // >= so a threshold lowered mid-count still gates on the next edge
          if (idle_cnt >= thresh_m1) begin
            state_nxt    = ST_GATED;
            idle_cnt_nxt = '0;
            gate_fire    = 1'b1;
          end else begin
            idle_cnt_nxt = idle_cnt + IDLE_ONE;
          end
        end else begin
          idle_cnt_nxt = '0;
        end
      end
      ST_GATED: begin
        if (busy || wake_req) begin
          state_nxt    = ST_WAKE;
          wake_cnt_nxt = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (wake_cnt == '0) begin
          state_nxt    = ST_RUN;
          idle_cnt_nxt = '0;
        end else begin
          wake_cnt_nxt = wake_cnt - WCNT_W'(1);
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    cg_en = cg_en_q | test_en;
    gated = gated_q;
  end

endmodule
